// File: rtl/des_decrypt_core_pkg.sv
// Shared DES constants: widths, FSM encodings, permutation/S-box tables and helper functions.
// Table entries use DES numbering (1 = MSB) so they read like the textbook tables.
package des_decrypt_core_pkg;

  localparam int BLK   = 64;
  localparam int HALF  = 32;
  localparam int KHALF = 28;
  localparam int SUBK  = 48;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Decrypt walks the key schedule backwards: K16 equals the PC1 value, then right rotations.
  localparam int RSH_TAB [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [BLK-1:0] perm64(input logic [BLK-1:0] x, input int tab [64]);
    logic [BLK-1:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[6'(BLK - 1 - i)] = x[6'(BLK - tab[i])];
    return r;
  endfunction

  function automatic logic [2*KHALF-1:0] pc1(input logic [BLK-1:0] x);
    logic [2*KHALF-1:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(2*KHALF - 1 - i)] = x[6'(BLK - PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [SUBK-1:0] pc2(input logic [2*KHALF-1:0] x);
    logic [SUBK-1:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(SUBK - 1 - i)] = x[6'(2*KHALF - PC2_TAB[i])];
    return r;
  endfunction

  function automatic logic [SUBK-1:0] e_expand(input logic [HALF-1:0] x);
    logic [SUBK-1:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(SUBK - 1 - i)] = x[5'(HALF - E_TAB[i])];
    return r;
  endfunction

  function automatic logic [HALF-1:0] p_perm(input logic [HALF-1:0] x);
    logic [HALF-1:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[5'(HALF - 1 - i)] = x[5'(HALF - P_TAB[i])];
    return r;
  endfunction

  // Row is the outer bit pair, column the inner four bits.
  function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] x);
    return 4'(SBOX[box][{x[5], x[0], x[4:1]}]);
  endfunction

  function automatic logic [KHALF-1:0] rotr(input logic [KHALF-1:0] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[0], x[KHALF-1:1]};
      2'd2:    return {x[1:0], x[KHALF-1:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_feistel_f.sv
// DES f-function: expand R, mix with the round subkey, eight S-boxes, then P-permutation.
module des_feistel_f
  import des_decrypt_core_pkg::*;
(
  input  logic [HALF-1:0] r_in,
  input  logic [SUBK-1:0] subkey,
  output logic [HALF-1:0] f_out
);

  logic [SUBK-1:0] mixed;
  logic [HALF-1:0] s_out;

  always_comb begin
    mixed = e_expand(r_in) ^ subkey;
    s_out = '0;
    for (int b = 0; b < 8; b++) begin
      s_out[5'(HALF - 1 - 4*b) -: 4] = sbox(3'(b), mixed[6'(SUBK - 1 - 6*b) -: 6]);
    end
  end

  assign f_out = p_perm(s_out);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys generated in reverse order.
module des_decrypt_core
  import des_decrypt_core_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BLK-1:0] ct_in,
  input  logic [BLK-1:0] key_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BLK-1:0] pt_out,
  output logic           busy
);

  logic [1:0]       state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [HALF-1:0]  l_q, l_d, r_q, r_d;
  logic [KHALF-1:0] c_q, c_d, d_q, d_d;
  logic [BLK-1:0]   pt_q, pt_d;

  logic [KHALF-1:0] c_rot, d_rot;
  logic [SUBK-1:0]  subkey;
  logic [HALF-1:0]  f_out, r_next;
  logic [1:0]       rsh;

  assign rsh    = 2'(RSH_TAB[rnd_q]);
  assign c_rot  = rotr(c_q, rsh);
  assign d_rot  = rotr(d_q, rsh);
  assign subkey = pc2({c_rot, d_rot});
  assign r_next = l_q ^ f_out;

  des_feistel_f u_f (
    .r_in   (r_q),
    .subkey (subkey),
    .f_out  (f_out)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so no branch leaves one unassigned (no inferred latch).
    state_d = state_q;
    rnd_d   = rnd_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    pt_d    = pt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = perm64(ct_in, IP_TAB);
          {c_d, d_d} = pc1(key_in);
          rnd_d      = 4'd0;
          state_d    = S_ROUND;
        end
      end
      S_ROUND: begin
        l_d   = r_q;
        r_d   = r_next;
        c_d   = c_rot;
        d_d   = d_rot;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(ROUNDS - 1)) begin
          // Final swap: output is FP(R16 || L16).
          pt_d    = perm64({r_next, r_q}, FP_TAB);
          rnd_d   = 4'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      pt_q    <= pt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign pt_out    = pt_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core using published DES known-answer vectors.
module tb_des_decrypt_core;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ct_in;
  logic [63:0] key_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pt_out;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT_B  = 64'h0000000000000000;
  localparam logic [63:0] PT_B  = 64'h8787878787878787;
  localparam logic [63:0] KEY_C = 64'h0000000000000000;
  localparam logic [63:0] CT_C  = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] PT_C  = 64'h0000000000000000;

  des_decrypt_core #(.ROUNDS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic [63:0] ct, input logic [63:0] key);
    int w;
    w = 0;
    in_valid = 1'b1;
    ct_in    = ct;
    key_in   = key;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    check({tag, " ready_wait"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] exp_pt);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd16);
    check({tag, " pt"}, pt_out, exp_pt);
  endtask

  task automatic handshake(input string tag, input logic [63:0] exp_pt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " ov_cleared"}, 64'(out_valid), 64'd0);
    check({tag, " idle_ready"}, 64'(in_ready), 64'd1);
    check({tag, " pt_kept"}, pt_out, exp_pt);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ct_in     = '0;
    key_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst pt_out", pt_out, 64'd0);

    // Known answer A, plain handshake.
    accept("kat_a", CT_A, KEY_A);
    check("kat_a in_ready_low", 64'(in_ready), 64'd0);
    wait_done("kat_a", PT_A);
    handshake("kat_a", PT_A);

    // Known answer B with five cycles of backpressure.
    accept("kat_b", CT_B, KEY_B);
    wait_done("kat_b", PT_B);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp pt_hold", pt_out, PT_B);
      check("bp ov_hold", 64'(out_valid), 64'd1);
      check("bp busy", 64'(busy), 64'd1);
    end
    handshake("kat_b", PT_B);

    // Reset at round 8 discards the block and clears pt_out.
    accept("rst_mid", CT_A, KEY_A);
    repeat (8) tick();
    check("rst_mid busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #2;
    check("rst_mid async ov", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b0;
    check("rst_mid in_ready", 64'(in_ready), 64'd1);
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid pt_out", pt_out, 64'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("rst_mid no_ov_pulse", 64'(n), 64'd0);
    accept("after_rst", CT_A, KEY_A);
    wait_done("after_rst", PT_A);
    handshake("after_rst", PT_A);

    // Busy protection: in_valid stays high while the first block is in flight.
    in_valid = 1'b1;
    ct_in    = CT_A;
    key_in   = KEY_A;
    tick();
    ct_in  = CT_C;
    key_in = KEY_C;
    check("busy1 accepted", 64'(busy), 64'd1);
    wait_done("busy1", PT_A);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("busy hs_no_accept", 64'(busy), 64'd0);
    check("busy hs_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("busy2 accepted", 64'(busy), 64'd1);
    wait_done("busy2", PT_C);
    handshake("busy2", PT_C);

    // Inputs scrambled every cycle after the accept edge.
    accept("stab", CT_B, KEY_B);
    n = 0;
    while (!out_valid && n < 40) begin
      ct_in  = {$urandom(), $urandom()};
      key_in = {$urandom(), $urandom()};
      tick();
      n++;
    end
    check("stab latency", 64'(n), 64'd16);
    check("stab pt", pt_out, PT_B);
    handshake("stab", PT_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
